// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder
// -----------------
// Bus-slave end of the multiplexed address/data RTC interface. It decodes the
// address and data phases, holds a BCD register file, advances time once per
// second and raises a sticky IRQ when the countdown timer expires.
//
// Optional feature: define RTC_CALENDAR_EN to let the hour roll-over carry
// into day/month/year. Without it, day/month/year are plain storage.
//
// Bus protocol (all strobes active-low, seen after SYNC_STAGES flops):
//   - A write happens on the synchronized rising edge of WR while CS is low.
//     AD=0 loads the address latch, AD=1 writes the addressed register.
//     The bus value is sampled through the same synchronizer depth as WR.
//   - While CS=0, RD=0 and AD=1 the addressed register is driven onto the
//     bus; otherwise the bus is high-impedance. If RD is still low when the
//     WR edge is seen, the read wins and the write is dropped.
//
// Register map: 0x00 ctrl, 0x21 sec, 0x22 min, 0x23 hour, 0x24 day,
//               0x25 month, 0x26 year, 0x41 tsec, 0x42 tmin, 0x43 thour.
//
// Ports:
//   CLK          in     system clock
//   Reset        in     asynchronous active-high reset
//   CS           in     chip select, active-low
//   AD           in     phase select (0 address, 1 data)
//   WR           in     write strobe, active-low
//   RD           in     read strobe, active-low
//   Bus_Dato_Dir inout  8-bit multiplexed address/data bus
//   IRQ          out    timer-expired flag, sticky, active-high

module rtc_bus_responder #(
    parameter int TICK_DIV    = 100000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       CS,
    input  logic       AD,
    input  logic       WR,
    input  logic       RD,
    inout  wire  [7:0] Bus_Dato_Dir,
    output logic       IRQ
);

    localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    // ------------------------------------------------------------------
    // BCD helpers. Results are {carry/borrow, value}.
    // ------------------------------------------------------------------
    // Increment; anything at/above max_v or with a non-decimal digit wraps
    // to min_v with carry.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] max_v,
                                           input logic [7:0] min_v);
        logic valid;
        valid = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
        if (!valid || (v >= max_v))
            bcd_inc = {1'b1, min_v};
        else if (v[3:0] == 4'd9)
            bcd_inc = {1'b0, v[7:4] + 4'd1, 4'h0};
        else
            bcd_inc = {1'b0, v + 8'd1};
    endfunction

    // Decrement for minutes/seconds fields: 0x00 borrows and becomes 0x59.
    function automatic logic [8:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)
            bcd_dec = {1'b1, 8'h59};
        else if (v[3:0] == 4'd0)
            bcd_dec = {1'b0, v[7:4] - 4'd1, 4'h9};
        else
            bcd_dec = {1'b0, v - 8'd1};
    endfunction

`ifdef RTC_CALENDAR_EN
    // BCD year divisible by 4: even tens digit with units 0/4/8, or odd
    // tens digit with units 2/6.
    function automatic logic is_leap(input logic [7:0] y);
        if (!y[4])
            is_leap = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
        else
            is_leap = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
    endfunction

    function automatic logic [7:0] month_len(input logic [7:0] m, input logic [7:0] y);
        case (m)
            8'h02:                      month_len = is_leap(y) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
            default:                    month_len = 8'h31;
        endcase
    endfunction
`endif

    // ------------------------------------------------------------------
    // Input synchronizers. Strobes reset to their inactive level so a
    // reset in mid-transaction releases the bus immediately and cannot
    // produce a write edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cs_sync_q, ad_sync_q, wr_sync_q, rd_sync_q;
    logic [7:0]             bus_sync_q [SYNC_STAGES];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cs_sync_q <= '1;
            ad_sync_q <= '0;
            wr_sync_q <= '1;
            rd_sync_q <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) bus_sync_q[i] <= '0;
        end else begin
            cs_sync_q <= (cs_sync_q << 1) | SYNC_STAGES'(CS);
            ad_sync_q <= (ad_sync_q << 1) | SYNC_STAGES'(AD);
            wr_sync_q <= (wr_sync_q << 1) | SYNC_STAGES'(WR);
            rd_sync_q <= (rd_sync_q << 1) | SYNC_STAGES'(RD);
            for (int i = SYNC_STAGES - 1; i > 0; i--) bus_sync_q[i] <= bus_sync_q[i-1];
            bus_sync_q[0] <= Bus_Dato_Dir;
        end
    end

    logic       cs_s, ad_s, wr_s, rd_s;
    logic [7:0] bus_s;

    assign cs_s  = cs_sync_q[SYNC_STAGES-1];
    assign ad_s  = ad_sync_q[SYNC_STAGES-1];
    assign wr_s  = wr_sync_q[SYNC_STAGES-1];
    assign rd_s  = rd_sync_q[SYNC_STAGES-1];
    assign bus_s = bus_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             wr_prev_q;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [7:0]       day_q, day_d, mon_q, mon_d, year_q, year_d;
    logic [7:0]       tsec_q, tsec_d, tmin_q, tmin_d, thour_q, thour_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             irq_q, irq_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_pend_q, tick_pend_d;

    logic       write_ev, addr_wr, data_wr, rd_active;
    logic       tick_raw, tick_due, tick_go;
    logic       timer_nz, irq_set, irq_clr;
    logic [8:0] t;
    logic [7:0] rdata;

    assign write_ev  = wr_s & ~wr_prev_q & ~cs_s & rd_s;
    assign addr_wr   = write_ev & ~ad_s;
    assign data_wr   = write_ev & ad_s;
    assign rd_active = ~cs_s & ~rd_s & ad_s;

    // A tick landing on a data write is held one cycle so the register
    // write and the time update never collide.
    assign tick_raw    = (div_q == DIV_LAST);
    assign tick_due    = tick_raw | tick_pend_q;
    assign tick_go     = tick_due & ~data_wr;
    assign tick_pend_d = tick_due & data_wr;
    assign div_d       = tick_raw ? '0 : div_q + 1'b1;
    assign timer_nz    = |{tsec_q, tmin_q, thour_q};

    always_comb begin
        addr_d  = addr_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = day_q;
        mon_d   = mon_q;
        year_d  = year_q;
        tsec_d  = tsec_q;
        tmin_d  = tmin_q;
        thour_d = thour_q;
        ctrl_d  = ctrl_q;
        irq_set = 1'b0;
        irq_clr = 1'b0;
        t       = '0;

        if (tick_go && !ctrl_q[0]) begin
            t = bcd_inc(sec_q, 8'h59, 8'h00);
            sec_d = t[7:0];
            if (t[8]) begin
                t = bcd_inc(min_q, 8'h59, 8'h00);
                min_d = t[7:0];
                if (t[8]) begin
                    t = bcd_inc(hour_q, 8'h23, 8'h00);
                    hour_d = t[7:0];
`ifdef RTC_CALENDAR_EN
                    if (t[8]) begin
                        t = bcd_inc(day_q, month_len(mon_q, year_q), 8'h01);
                        day_d = t[7:0];
                        if (t[8]) begin
                            t = bcd_inc(mon_q, 8'h12, 8'h01);
                            mon_d = t[7:0];
                            if (t[8]) begin
                                t = bcd_inc(year_q, 8'h99, 8'h00);
                                year_d = t[7:0];
                            end
                        end
                    end
`endif
                end
            end
        end

        if (tick_go && ctrl_q[1] && timer_nz) begin
            t = bcd_dec(tsec_q);
            tsec_d = t[7:0];
            if (t[8]) begin
                t = bcd_dec(tmin_q);
                tmin_d = t[7:0];
                if (t[8]) begin
                    t = bcd_dec(thour_q);
                    thour_d = t[7:0];
                end
            end
            irq_set = ({tsec_d, tmin_d, thour_d} == 24'h0);
        end

        if (addr_wr) addr_d = bus_s;

        if (data_wr) begin
            case (addr_q)
                8'h00: begin
                    ctrl_d  = bus_s[1:0];
                    irq_clr = bus_s[2];
                end
                8'h21: sec_d   = bus_s;
                8'h22: min_d   = bus_s;
                8'h23: hour_d  = bus_s;
                8'h24: day_d   = bus_s;
                8'h25: mon_d   = bus_s;
                8'h26: year_d  = bus_s;
                8'h41: tsec_d  = bus_s;
                8'h42: tmin_d  = bus_s;
                8'h43: thour_d = bus_s;
                default: ;
            endcase
        end

        // Set has priority over a simultaneous clear.
        irq_d = irq_set ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_prev_q   <= 1'b1;
            addr_q      <= 8'h00;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hour_q      <= 8'h00;
            day_q       <= 8'h01;
            mon_q       <= 8'h01;
            year_q      <= 8'h00;
            tsec_q      <= 8'h00;
            tmin_q      <= 8'h00;
            thour_q     <= 8'h00;
            ctrl_q      <= 2'b00;
            irq_q       <= 1'b0;
            div_q       <= '0;
            tick_pend_q <= 1'b0;
        end else begin
            wr_prev_q   <= wr_s;
            addr_q      <= addr_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            mon_q       <= mon_d;
            year_q      <= year_d;
            tsec_q      <= tsec_d;
            tmin_q      <= tmin_d;
            thour_q     <= thour_d;
            ctrl_q      <= ctrl_d;
            irq_q       <= irq_d;
            div_q       <= div_d;
            tick_pend_q <= tick_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 8'h00;
        case (addr_q)
            8'h00: rdata = {6'b0, ctrl_q};
            8'h21: rdata = sec_q;
            8'h22: rdata = min_q;
            8'h23: rdata = hour_q;
            8'h24: rdata = day_q;
            8'h25: rdata = mon_q;
            8'h26: rdata = year_q;
            8'h41: rdata = tsec_q;
            8'h42: rdata = tmin_q;
            8'h43: rdata = thour_q;
            default: rdata = 8'h00;
        endcase
    end

    assign Bus_Dato_Dir = rd_active ? rdata : 8'hzz;
    assign IRQ          = irq_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Testbench for rtc_bus_responder: directed bus sequences plus a randomized
// phase, checked against a register/time model that works in plain decimal
// seconds, minutes and hours.
module tb_rtc_bus_responder;
  localparam int TD = 50;
  localparam int SS = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b1, ad = 1'b0, wr = 1'b1, rd = 1'b1;
  logic irq;
  logic [7:0] drv = 8'h00;
  logic oe = 1'b0;
  wire [7:0] bus;

  assign bus = oe ? drv : 8'hzz;
  pullup (bus);

  always #5 clk = ~clk;

  rtc_bus_responder #(.TICK_DIV(TD), .SYNC_STAGES(SS)) dut (
    .CLK(clk), .Reset(rst), .CS(cs), .AD(ad), .WR(wr), .RD(rd),
    .Bus_Dato_Dir(bus), .IRQ(irq)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model
  logic [7:0] m_reg [256];
  logic [1:0] m_ctrl;
  logic m_irq;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic bit mapped(input logic [7:0] a);
    return (a == 8'h00) || (a >= 8'h21 && a <= 8'h26) || (a >= 8'h41 && a <= 8'h43);
  endfunction

  function automatic int dec(input logic [7:0] v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic int mlen(input logic [7:0] mon, input logic [7:0] yr);
    int m = dec(mon);
    int y = dec(yr);
    if (m == 2) return (y >= 0 && y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic step_unit(input logic [7:0] v, input int top, input int lo,
                           output logic [7:0] nv, output bit carry);
    int d = dec(v);
    if (d < 0 || d >= top) begin
      nv = bcd(lo);
      carry = 1'b1;
    end else begin
      nv = bcd(d + 1);
      carry = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_reg[i] = 8'h00;
    m_reg[8'h24] = 8'h01;
    m_reg[8'h25] = 8'h01;
    m_ctrl = 2'b00;
    m_irq = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (!mapped(a)) return;
    if (a == 8'h00) begin
      m_ctrl = d[1:0];
      if (d[2]) m_irq = 1'b0;
    end else begin
      m_reg[a] = d;
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a == 8'h00) return {6'b0, m_ctrl};
    if (mapped(a)) return m_reg[a];
    return 8'h00;
  endfunction

  task automatic model_tick();
    logic [7:0] nv;
    bit c;
    int tot;
    if (!m_ctrl[0]) begin
      step_unit(m_reg[8'h21], 59, 0, nv, c); m_reg[8'h21] = nv;
      if (c) begin
        step_unit(m_reg[8'h22], 59, 0, nv, c); m_reg[8'h22] = nv;
        if (c) begin
          step_unit(m_reg[8'h23], 23, 0, nv, c); m_reg[8'h23] = nv;
`ifdef RTC_CALENDAR_EN
          if (c) begin
            step_unit(m_reg[8'h24], mlen(m_reg[8'h25], m_reg[8'h26]), 1, nv, c); m_reg[8'h24] = nv;
            if (c) begin
              step_unit(m_reg[8'h25], 12, 1, nv, c); m_reg[8'h25] = nv;
              if (c) begin
                step_unit(m_reg[8'h26], 99, 0, nv, c); m_reg[8'h26] = nv;
              end
            end
          end
`endif
        end
      end
    end
    tot = dec(m_reg[8'h43]) * 3600 + dec(m_reg[8'h42]) * 60 + dec(m_reg[8'h41]);
    if (m_ctrl[1] && tot > 0) begin
      tot--;
      m_reg[8'h43] = bcd(tot / 3600);
      m_reg[8'h42] = bcd((tot / 60) % 60);
      m_reg[8'h41] = bcd(tot % 60);
      if (tot == 0) m_irq = 1'b1;
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    cyc++;
    if (cyc % TD == 0) model_tick();
    @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    int target = (cyc / TD + n) * TD;
    while (cyc < target) step();
    step();
  endtask

  // Keep whole transactions clear of tick edges so the model ordering is exact.
  task automatic guard();
    while ((cyc % TD) < 3 || (cyc % TD) > 30) step();
  endtask

  task automatic phase_write(input logic adv, input logic [7:0] val);
    cs = 1'b0; ad = adv; drv = val; oe = 1'b1; wr = 1'b0;
    repeat (4) step();
    wr = 1'b1;
    repeat (3) step();
    cs = 1'b1; oe = 1'b0;
    repeat (2) step();
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    guard();
    phase_write(1'b0, a);
    phase_write(1'b1, d);
    model_write(a, d);
  endtask

  task automatic read_check(input string tag, input logic [7:0] a);
    logic [7:0] got;
    guard();
    phase_write(1'b0, a);
    cs = 1'b0; ad = 1'b1; rd = 1'b0;
    repeat (SS + 1) step();
    got = bus;
    check(tag, got, model_read(a));
    rd = 1'b1; cs = 1'b1;
    repeat (SS + 1) step();
    check({tag, "_release"}, bus, 8'hFF);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cs = 1'b1; ad = 1'b0; wr = 1'b1; rd = 1'b1; oe = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    model_reset();
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus_write(8'h00, 8'h01);
    bus_write(8'h23, h);
    bus_write(8'h22, m);
    bus_write(8'h21, s);
  endtask

  // watchdog
  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // main sequence
  initial begin
    logic [7:0] a;
    model_reset();
    do_reset();

    // reset state
    check("irq_reset", irq, 8'h00);
    check("bus_idle", bus, 8'hFF);
    read_check("day_reset", 8'h24);
    read_check("mon_reset", 8'h25);
    read_check("sec_reset", 8'h21);
    read_check("ctrl_reset", 8'h00);

    // basic advance with carry into minutes
    bus_write(8'h23, 8'h08);
    bus_write(8'h22, 8'h10);
    bus_write(8'h21, 8'h59);
    wait_ticks(1);
    read_check("sec_carry", 8'h21);
    read_check("min_carry", 8'h22);
    read_check("hour_keep", 8'h23);

    // midnight roll-over
`ifdef RTC_CALENDAR_EN
    bus_write(8'h24, 8'h28); bus_write(8'h25, 8'h02); bus_write(8'h26, 8'h16);
    set_time(8'h23, 8'h59, 8'h59);
    bus_write(8'h00, 8'h00);
    wait_ticks(1);
    read_check("hour_wrap", 8'h23);
    read_check("day_leap", 8'h24);
    read_check("mon_leap", 8'h25);
    bus_write(8'h24, 8'h28); bus_write(8'h25, 8'h02); bus_write(8'h26, 8'h15);
    set_time(8'h23, 8'h59, 8'h59);
    bus_write(8'h00, 8'h00);
    wait_ticks(1);
    read_check("day_noleap", 8'h24);
    read_check("mon_noleap", 8'h25);
    bus_write(8'h24, 8'h31); bus_write(8'h25, 8'h12); bus_write(8'h26, 8'h99);
    set_time(8'h23, 8'h59, 8'h59);
    bus_write(8'h00, 8'h00);
    wait_ticks(1);
    read_check("day_ny", 8'h24);
    read_check("mon_ny", 8'h25);
    read_check("year_ny", 8'h26);
`else
    bus_write(8'h24, 8'h28);
    set_time(8'h23, 8'h59, 8'h59);
    bus_write(8'h00, 8'h00);
    wait_ticks(1);
    read_check("hour_wrap", 8'h23);
    read_check("min_wrap", 8'h22);
    read_check("day_nocarry", 8'h24);
`endif

    // countdown timer
    bus_write(8'h41, 8'h02);
    bus_write(8'h00, 8'h02);
    wait_ticks(2);
    read_check("tsec_zero", 8'h41);
    check("irq_set", irq, {7'b0, m_irq});
    wait_ticks(1);
    read_check("tsec_hold", 8'h41);
    read_check("tmin_hold", 8'h42);
    bus_write(8'h00, 8'h06);
    check("irq_clr", irq, {7'b0, m_irq});
    read_check("ctrl_rb", 8'h00);
    bus_write(8'h43, 8'h01);
    wait_ticks(1);
    read_check("tsec_borrow", 8'h41);
    read_check("tmin_borrow", 8'h42);
    read_check("thour_borrow", 8'h43);

    // halt and unmapped
    bus_write(8'h00, 8'h01);
    wait_ticks(5);
    read_check("sec_halt", 8'h21);
    read_check("unmapped_rd", 8'h7F);
    bus_write(8'h7F, 8'h55);
    read_check("unmapped_wr", 8'h7F);

    // randomized phase
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 6))
        0: bus_write(8'h21 + 8'($urandom_range(0, 1)), bcd($urandom_range(0, 59)));
        1: bus_write(8'h23, bcd($urandom_range(0, 23)));
        2: bus_write(8'h41 + 8'($urandom_range(0, 1)), bcd($urandom_range(0, 2)));
        3: bus_write(8'h00, 8'($urandom_range(0, 7)));
        4: begin
          a = 8'($urandom_range(0, 255));
          read_check("rand_any", a);
        end
        5: begin
          case ($urandom_range(0, 3))
            0: a = 8'h00;
            1: a = 8'h21 + 8'($urandom_range(0, 5));
            2: a = 8'h41 + 8'($urandom_range(0, 2));
            default: a = 8'($urandom_range(0, 255));
          endcase
          read_check("rand_reg", a);
        end
        default: begin
          repeat ($urandom_range(1, 120)) step();
          check("rand_irq", irq, {7'b0, m_irq});
        end
      endcase
    end

    // reset during a read data phase
    bus_write(8'h00, 8'h00);
    bus_write(8'h41, 8'h01);
    bus_write(8'h22, 8'h37);
    bus_write(8'h00, 8'h02);
    wait_ticks(1);
    check("irq_pre_rst", irq, {7'b0, m_irq});
    guard();
    phase_write(1'b0, 8'h22);
    cs = 1'b0; ad = 1'b1; rd = 1'b0;
    repeat (SS + 1) step();
    check("rd_pre_rst", bus, model_read(8'h22));
    rst = 1'b1;
    #1;
    check("rst_bus_hiz", bus, 8'hFF);
    check("rst_irq", irq, 8'h00);
    @(negedge clk);
    do_reset();
    read_check("min_after_rst", 8'h22);
    read_check("tsec_after_rst", 8'h41);
    read_check("day_after_rst", 8'h24);
    read_check("ctrl_after_rst", 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
